// File: rtl/gba_line_cache_pkg.sv
// Shared sizes and pixel type for the GBA four-line cache.
package gba_line_cache_pkg;

  localparam int GBA_LINE_PXLS   = 240;
  localparam int GBA_FRAME_LINES = 160;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb24_t;

endpackage

// File: rtl/line_bank.sv
// One cached GBA line: single write port, three asynchronous read taps (x-1, x, x+1).
module line_bank
  import gba_line_cache_pkg::*;
#(
  parameter int LINE_PXLS = GBA_LINE_PXLS
) (
  input  logic        pxlClk,
  input  logic        wrEn,
  input  logic [7:0]  wrAddr,
  input  logic [23:0] wrData,
  input  logic [7:0]  rdAddrPrev,
  input  logic [7:0]  rdAddrCur,
  input  logic [7:0]  rdAddrNext,
  output logic [23:0] rdDataPrev,
  output logic [23:0] rdDataCur,
  output logic [23:0] rdDataNext
);

  logic [23:0] mem [LINE_PXLS];

  always_ff @(posedge pxlClk) begin
    if (wrEn) mem[wrAddr] <= wrData;
  end

  assign rdDataPrev = mem[rdAddrPrev];
  assign rdDataCur  = mem[rdAddrCur];
  assign rdDataNext = mem[rdAddrNext];

endmodule

// File: rtl/gba_line_cache.sv
// Four-line ring buffer feeding a registered 3x3 RGB window to the HDMI image generator.
module gba_line_cache
  import gba_line_cache_pkg::*;
#(
  parameter int LINE_PXLS   = GBA_LINE_PXLS,
  parameter int FRAME_LINES = GBA_FRAME_LINES
) (
  input  logic       pxlClk,
  input  logic       rst,
  input  logic       wrFrameStart,
  input  logic       wrEn,
  input  logic [7:0] wrRed,
  input  logic [7:0] wrGreen,
  input  logic [7:0] wrBlue,
  input  logic [7:0] curPxl,
  input  logic       nextLine,
  input  logic       cacheUpdate,
  output logic [7:0] prevLinePrevPxlRedOut,
  output logic [7:0] prevLinePrevPxlGreenOut,
  output logic [7:0] prevLinePrevPxlBlueOut,
  output logic [7:0] prevLineCurPxlRedOut,
  output logic [7:0] prevLineCurPxlGreenOut,
  output logic [7:0] prevLineCurPxlBlueOut,
  output logic [7:0] prevLineNextPxlRedOut,
  output logic [7:0] prevLineNextPxlGreenOut,
  output logic [7:0] prevLineNextPxlBlueOut,
  output logic [7:0] curLinePrevPxlRedOut,
  output logic [7:0] curLinePrevPxlGreenOut,
  output logic [7:0] curLinePrevPxlBlueOut,
  output logic [7:0] curLineCurPxlRedOut,
  output logic [7:0] curLineCurPxlGreenOut,
  output logic [7:0] curLineCurPxlBlueOut,
  output logic [7:0] curLineNextPxlRedOut,
  output logic [7:0] curLineNextPxlGreenOut,
  output logic [7:0] curLineNextPxlBlueOut,
  output logic [7:0] nextLinePrevPxlRedOut,
  output logic [7:0] nextLinePrevPxlGreenOut,
  output logic [7:0] nextLinePrevPxlBlueOut,
  output logic [7:0] nextLineCurPxlRedOut,
  output logic [7:0] nextLineCurPxlGreenOut,
  output logic [7:0] nextLineCurPxlBlueOut,
  output logic [7:0] nextLineNextPxlRedOut,
  output logic [7:0] nextLineNextPxlGreenOut,
  output logic [7:0] nextLineNextPxlBlueOut,
  output logic       sameLine,
  output logic       newFrameOut,
  output logic       overflow
);

  localparam logic [7:0] LAST_PXL   = 8'(LINE_PXLS - 1);
  localparam logic [7:0] LAST_LINE  = 8'(FRAME_LINES - 1);
  localparam logic [7:0] FRAME_END  = 8'(FRAME_LINES);
  localparam logic [8:0] FRAME_END9 = 9'(FRAME_LINES);
  localparam logic [7:0] WIN_READY  = 8'((FRAME_LINES < 2) ? FRAME_LINES : 2);
  localparam logic [1:0] LINE0_NEXT = (FRAME_LINES > 1) ? 2'd1 : 2'd0;

  logic [7:0] wrPxlCnt, linesDone, rdLine;
  logic [1:0] prevBank, curBank, nextBank;
  logic [1:0] mapPrev, mapCur, mapNext;
  logic [7:0] mapLine;
  logic [8:0] rdPlus3, readyLimit;
  logic       nextAcc, wrAccept;
  logic [7:0] wrAddr;
  logic [1:0] wrBank;
  rgb24_t     wrData;
  logic [7:0] xPrev, xCur, xNext;
  logic [23:0] bankPrevData [4];
  logic [23:0] bankCurData  [4];
  logic [23:0] bankNextData [4];
  logic [1:0] rowBank [3];
  rgb24_t     win [3][3];

  // A frame-start pixel always lands at pixel 0 of line 0, even after a full frame.
  assign wrAccept = wrEn && (wrFrameStart || (linesDone != FRAME_END));
  assign wrAddr   = wrFrameStart ? 8'd0 : wrPxlCnt;
  assign wrBank   = wrFrameStart ? 2'd0 : linesDone[1:0];
  assign wrData   = '{red: wrRed, green: wrGreen, blue: wrBlue};

  assign rdPlus3    = {1'b0, rdLine} + 9'd3;
  assign readyLimit = (rdPlus3 > FRAME_END9) ? FRAME_END9 : rdPlus3;
  assign sameLine   = (rdLine == LAST_LINE) || ({1'b0, linesDone} < readyLimit) || newFrameOut;
  assign nextAcc    = nextLine && !sameLine;

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      wrPxlCnt    <= '0;
      linesDone   <= '0;
      rdLine      <= '0;
      newFrameOut <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= wrAccept && !wrFrameStart && (wrPxlCnt == 8'd0) &&
                  (wrBank == prevBank) && ({1'b0, linesDone} == rdPlus3);
      if (wrFrameStart) begin
        wrPxlCnt    <= wrEn ? 8'd1 : 8'd0;
        linesDone   <= '0;
        rdLine      <= '0;
        newFrameOut <= 1'b1;
      end else begin
        if (wrAccept) begin
          if (wrPxlCnt == LAST_PXL) begin
            wrPxlCnt  <= '0;
            linesDone <= linesDone + 8'd1;
          end else begin
            wrPxlCnt <= wrPxlCnt + 8'd1;
          end
        end
        if (nextAcc) rdLine <= rdLine + 8'd1;
        if (newFrameOut && (linesDone >= WIN_READY)) newFrameOut <= 1'b0;
      end
    end
  end

  // Mapping targets the line being read after this edge, with top/bottom rows clamped.
  always_comb begin
    mapLine = rdLine + {7'd0, nextAcc};
    mapCur  = mapLine[1:0];
    mapPrev = (mapLine == 8'd0) ? mapCur : (mapLine[1:0] - 2'd1);
    mapNext = (mapLine == LAST_LINE) ? mapCur : (mapLine[1:0] + 2'd1);
  end

  always_ff @(posedge pxlClk) begin
    if (rst || wrFrameStart) begin
      prevBank <= 2'd0;
      curBank  <= 2'd0;
      nextBank <= LINE0_NEXT;
    end else if (cacheUpdate) begin
      prevBank <= mapPrev;
      curBank  <= mapCur;
      nextBank <= mapNext;
    end
  end

  assign xCur  = (curPxl > LAST_PXL) ? LAST_PXL : curPxl;
  assign xPrev = (xCur == 8'd0) ? 8'd0 : (xCur - 8'd1);
  assign xNext = (xCur == LAST_PXL) ? xCur : (xCur + 8'd1);

  for (genvar b = 0; b < 4; b++) begin : g_bank
    line_bank #(.LINE_PXLS(LINE_PXLS)) u_bank (
      .pxlClk     (pxlClk),
      .wrEn       (wrAccept && (wrBank == 2'(b))),
      .wrAddr     (wrAddr),
      .wrData     (wrData),
      .rdAddrPrev (xPrev),
      .rdAddrCur  (xCur),
      .rdAddrNext (xNext),
      .rdDataPrev (bankPrevData[b]),
      .rdDataCur  (bankCurData[b]),
      .rdDataNext (bankNextData[b])
    );
  end

  assign rowBank[0] = prevBank;
  assign rowBank[1] = curBank;
  assign rowBank[2] = nextBank;

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= bankPrevData[rowBank[r]];
        win[r][1] <= bankCurData[rowBank[r]];
        win[r][2] <= bankNextData[rowBank[r]];
      end
    end
  end

  assign prevLinePrevPxlRedOut   = win[0][0].red;
  assign prevLinePrevPxlGreenOut = win[0][0].green;
  assign prevLinePrevPxlBlueOut  = win[0][0].blue;
  assign prevLineCurPxlRedOut    = win[0][1].red;
  assign prevLineCurPxlGreenOut  = win[0][1].green;
  assign prevLineCurPxlBlueOut   = win[0][1].blue;
  assign prevLineNextPxlRedOut   = win[0][2].red;
  assign prevLineNextPxlGreenOut = win[0][2].green;
  assign prevLineNextPxlBlueOut  = win[0][2].blue;
  assign curLinePrevPxlRedOut    = win[1][0].red;
  assign curLinePrevPxlGreenOut  = win[1][0].green;
  assign curLinePrevPxlBlueOut   = win[1][0].blue;
  assign curLineCurPxlRedOut     = win[1][1].red;
  assign curLineCurPxlGreenOut   = win[1][1].green;
  assign curLineCurPxlBlueOut    = win[1][1].blue;
  assign curLineNextPxlRedOut    = win[1][2].red;
  assign curLineNextPxlGreenOut  = win[1][2].green;
  assign curLineNextPxlBlueOut   = win[1][2].blue;
  assign nextLinePrevPxlRedOut   = win[2][0].red;
  assign nextLinePrevPxlGreenOut = win[2][0].green;
  assign nextLinePrevPxlBlueOut  = win[2][0].blue;
  assign nextLineCurPxlRedOut    = win[2][1].red;
  assign nextLineCurPxlGreenOut  = win[2][1].green;
  assign nextLineCurPxlBlueOut   = win[2][1].blue;
  assign nextLineNextPxlRedOut   = win[2][2].red;
  assign nextLineNextPxlGreenOut = win[2][2].green;
  assign nextLineNextPxlBlueOut  = win[2][2].blue;

endmodule

// File: tb/tb_gba_line_cache.sv
// Directed bench for gba_line_cache: pixels carry red = line, green = x, blue = x ^ line.
module tb_gba_line_cache;

  logic       pxlClk = 1'b0;
  logic       rst = 1'b1;
  logic       wrFrameStart = 1'b0;
  logic       wrEn = 1'b0;
  logic [7:0] wrRed = '0, wrGreen = '0, wrBlue = '0;
  logic [7:0] curPxl = '0;
  logic       nextLine = 1'b0;
  logic       cacheUpdate = 1'b0;
  logic [7:0] winRed [3][3];
  logic [7:0] winGreen [3][3];
  logic [7:0] winBlue [3][3];
  logic       sameLine, newFrameOut, overflow;
  int         checks = 0;
  int         errors = 0;

  always #5 pxlClk = ~pxlClk;

  gba_line_cache dut (
    .pxlClk(pxlClk), .rst(rst), .wrFrameStart(wrFrameStart), .wrEn(wrEn),
    .wrRed(wrRed), .wrGreen(wrGreen), .wrBlue(wrBlue), .curPxl(curPxl),
    .nextLine(nextLine), .cacheUpdate(cacheUpdate),
    .prevLinePrevPxlRedOut(winRed[0][0]), .prevLinePrevPxlGreenOut(winGreen[0][0]), .prevLinePrevPxlBlueOut(winBlue[0][0]),
    .prevLineCurPxlRedOut(winRed[0][1]),  .prevLineCurPxlGreenOut(winGreen[0][1]),  .prevLineCurPxlBlueOut(winBlue[0][1]),
    .prevLineNextPxlRedOut(winRed[0][2]), .prevLineNextPxlGreenOut(winGreen[0][2]), .prevLineNextPxlBlueOut(winBlue[0][2]),
    .curLinePrevPxlRedOut(winRed[1][0]),  .curLinePrevPxlGreenOut(winGreen[1][0]),  .curLinePrevPxlBlueOut(winBlue[1][0]),
    .curLineCurPxlRedOut(winRed[1][1]),   .curLineCurPxlGreenOut(winGreen[1][1]),   .curLineCurPxlBlueOut(winBlue[1][1]),
    .curLineNextPxlRedOut(winRed[1][2]),  .curLineNextPxlGreenOut(winGreen[1][2]),  .curLineNextPxlBlueOut(winBlue[1][2]),
    .nextLinePrevPxlRedOut(winRed[2][0]), .nextLinePrevPxlGreenOut(winGreen[2][0]), .nextLinePrevPxlBlueOut(winBlue[2][0]),
    .nextLineCurPxlRedOut(winRed[2][1]),  .nextLineCurPxlGreenOut(winGreen[2][1]),  .nextLineCurPxlBlueOut(winBlue[2][1]),
    .nextLineNextPxlRedOut(winRed[2][2]), .nextLineNextPxlGreenOut(winGreen[2][2]), .nextLineNextPxlBlueOut(winBlue[2][2]),
    .sameLine(sameLine), .newFrameOut(newFrameOut), .overflow(overflow)
  );

  task automatic tick();
    @(posedge pxlClk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic writePixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    wrEn = 1'b1; wrRed = r; wrGreen = g; wrBlue = b;
    tick();
    wrEn = 1'b0;
  endtask

  task automatic writePixels(input int line, input int fromX, input int toX);
    for (int x = fromX; x <= toX; x++) writePixel(8'(line), 8'(x), 8'(x) ^ 8'(line));
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic cu, input logic nl);
    curPxl = x; cacheUpdate = cu; nextLine = nl;
    tick();
    cacheUpdate = 1'b0; nextLine = 1'b0;
  endtask

  initial begin
    tick(); tick();
    checkOutput("reset_win_cc_red", winRed[1][1], 8'd0);
    checkOutput("reset_win_nn_blue", winBlue[2][2], 8'd0);
    checkOutput("reset_sameLine", 8'(sameLine), 8'd1);
    checkOutput("reset_newFrameOut", 8'(newFrameOut), 8'd0);
    checkOutput("reset_overflow", 8'(overflow), 8'd0);
    rst = 1'b0;

    wrFrameStart = 1'b1;
    tick();
    wrFrameStart = 1'b0;
    checkOutput("fs_newFrameOut", 8'(newFrameOut), 8'd1);

    writePixels(0, 0, 239);
    checkOutput("line0_newFrameOut", 8'(newFrameOut), 8'd1);
    checkOutput("line0_sameLine", 8'(sameLine), 8'd1);
    writePixels(1, 0, 239);
    checkOutput("line1_done_newFrameOut", 8'(newFrameOut), 8'd1);
    tick();
    checkOutput("line1_after_newFrameOut", 8'(newFrameOut), 8'd0);
    checkOutput("line1_after_sameLine", 8'(sameLine), 8'd1);
    writePixels(2, 0, 239);
    checkOutput("line2_sameLine", 8'(sameLine), 8'd0);

    // Window around x=5 on line 0: top edge duplicates line 0 into the prev row.
    applyStimulus(8'd5, 1'b1, 1'b0);
    applyStimulus(8'd5, 1'b0, 1'b0);
    checkOutput("l0_prev_red", winRed[0][1], 8'd0);
    checkOutput("l0_cur_red", winRed[1][1], 8'd0);
    checkOutput("l0_next_red", winRed[2][1], 8'd1);
    checkOutput("l0_green_prev", winGreen[1][0], 8'd4);
    checkOutput("l0_green_cur", winGreen[1][1], 8'd5);
    checkOutput("l0_green_next", winGreen[1][2], 8'd6);
    checkOutput("l0_next_blue_next", winBlue[2][2], 8'd7);

    applyStimulus(8'd5, 1'b1, 1'b1);
    checkOutput("l1_sameLine", 8'(sameLine), 8'd1);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("l1_x0_prev_red", winRed[0][0], 8'd0);
    checkOutput("l1_x0_cur_red", winRed[1][1], 8'd1);
    checkOutput("l1_x0_next_red", winRed[2][2], 8'd2);
    checkOutput("l1_x0_green_prev", winGreen[1][0], 8'd0);
    checkOutput("l1_x0_green_next", winGreen[1][2], 8'd1);
    applyStimulus(8'd239, 1'b0, 1'b0);
    checkOutput("l1_x239_green_prev", winGreen[1][0], 8'd238);
    checkOutput("l1_x239_green_next", winGreen[1][2], 8'd239);
    applyStimulus(8'd250, 1'b0, 1'b0);
    checkOutput("l1_x250_green_cur", winGreen[2][1], 8'd239);
    checkOutput("l1_x250_green_next", winGreen[2][2], 8'd239);

    // Line 3 lands in bank 3 (not prev); line 4 reuses bank 0 = prev of line 1.
    writePixels(3, 0, 0);
    checkOutput("ovf_line3_first", 8'(overflow), 8'd0);
    writePixels(3, 1, 239);
    writePixels(4, 0, 0);
    checkOutput("ovf_line4_first", 8'(overflow), 8'd1);
    writePixels(4, 1, 1);
    checkOutput("ovf_line4_second", 8'(overflow), 8'd0);
    writePixels(4, 2, 239);
    for (int l = 5; l < 160; l++) writePixels(l, 0, 239);

    for (int i = 0; i < 158; i++) applyStimulus(8'd5, 1'b1, 1'b1);
    applyStimulus(8'd5, 1'b0, 1'b0);
    checkOutput("l159_sameLine", 8'(sameLine), 8'd1);
    checkOutput("l159_prev_red", winRed[0][1], 8'd158);
    checkOutput("l159_cur_red", winRed[1][1], 8'd159);
    checkOutput("l159_next_red", winRed[2][1], 8'd159);
    checkOutput("l159_green_next", winGreen[1][2], 8'd6);
    applyStimulus(8'd5, 1'b1, 1'b1);
    applyStimulus(8'd5, 1'b0, 1'b0);
    checkOutput("l159_hold_cur_red", winRed[1][1], 8'd159);
    checkOutput("l159_hold_prev_red", winRed[0][1], 8'd158);

    wrFrameStart = 1'b1; nextLine = 1'b1;
    writePixel(8'h77, 8'h11, 8'h33);
    wrFrameStart = 1'b0; nextLine = 1'b0;
    checkOutput("fs2_newFrameOut", 8'(newFrameOut), 8'd1);
    checkOutput("fs2_sameLine", 8'(sameLine), 8'd1);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("fs2_cur_red", winRed[1][1], 8'h77);
    checkOutput("fs2_prev_red", winRed[0][1], 8'h77);
    checkOutput("fs2_next_red", winRed[2][1], 8'd157);
    writePixel(8'h78, 8'h22, 8'h44);
    applyStimulus(8'd0, 1'b0, 1'b0);
    checkOutput("fs2_second_pixel_green", winGreen[1][2], 8'h22);

    writePixels(0, 2, 4);
    rst = 1'b1;
    tick();
    checkOutput("midreset_overflow", 8'(overflow), 8'd0);
    checkOutput("midreset_cur_red", winRed[1][1], 8'd0);
    checkOutput("midreset_newFrameOut", 8'(newFrameOut), 8'd0);
    checkOutput("midreset_sameLine", 8'(sameLine), 8'd1);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
